// File: rtl/ddr_fifo_pattern_gen.sv
// Write-side stimulus source for the DDR FIFO loopback test.
// Emits an incrementing DATA_W-bit counter on a valid/ready stream. It can
// insert gaps between bursts and stops after a programmable number of
// all-ones words (wraps) have been accepted.
module ddr_fifo_pattern_gen #(
  parameter int unsigned       DATA_W     = 32,
  parameter logic [DATA_W-1:0] START_VAL  = '0,
  parameter int unsigned       BURST_LEN  = 0,
  parameter int unsigned       GAP_CYCLES = 0,
  parameter int unsigned       MAX_WRAPS  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_data_valid,
  input  logic              wr_data_ready,
  output logic [31:0]       wrap_count,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_DONE
  } state_e;

  localparam logic [31:0] BURST_W  = 32'(BURST_LEN);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES) - 32'd1;
  localparam logic [31:0] MAX_W    = 32'(MAX_WRAPS);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [31:0]       wrap_q, wrap_d;
  logic [31:0]       burst_q, burst_d;
  logic [31:0]       gap_q, gap_d;
  logic              stop_pend_q, stop_pend_d;
  logic              done_q, done_d;

  logic              accept;
  logic              all_ones;
  logic [31:0]       wrap_inc;
  logic [31:0]       burst_inc;
  logic              max_hit;

  assign accept    = (state_q == S_RUN) && wr_data_ready;
  assign all_ones  = &data_q;
  // The wrap counter saturates instead of rolling over.
  assign wrap_inc  = (wrap_q == 32'hFFFF_FFFF) ? wrap_q : wrap_q + 32'd1;
  assign burst_inc = burst_q + 32'd1;
  assign max_hit   = (MAX_WRAPS != 0) && all_ones && (wrap_inc == MAX_W);

  // Next-state logic: run control, counter advance, wrap/burst/gap tracking.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d     = state_q;
    data_d      = data_q;
    wrap_d      = wrap_q;
    burst_d     = burst_q;
    gap_d       = gap_q;
    stop_pend_d = stop_pend_q;
    done_d      = done_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // stop wins over start in the same cycle.
        if (start && !stop) begin
          state_d     = S_RUN;
          data_d      = START_VAL;
          wrap_d      = '0;
          burst_d     = '0;
          gap_d       = '0;
          stop_pend_d = 1'b0;
          done_d      = 1'b0;
        end
      end

      S_RUN: begin
        if (accept) begin
          data_d      = data_q + DATA_W'(1);
          burst_d     = burst_inc;
          stop_pend_d = 1'b0;
          if (all_ones) wrap_d = wrap_inc;
          if (max_hit) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (stop || stop_pend_q) begin
            state_d = S_IDLE;
          end else if ((BURST_LEN != 0) && (burst_inc == BURST_W)) begin
            burst_d = '0;
            if (GAP_CYCLES != 0) begin
              state_d = S_GAP;
              gap_d   = '0;
            end
          end
        end else if (stop) begin
          // The word on the bus must still be delivered; remember the request.
          stop_pend_d = 1'b1;
        end
      end

      S_GAP: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (gap_q == GAP_LAST) begin
          state_d = S_RUN;
          gap_d   = '0;
          burst_d = '0;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  // NOTE: all registers, including the data word, reset asynchronously so no half-issued beat survives reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      data_q      <= START_VAL;
      wrap_q      <= '0;
      burst_q     <= '0;
      gap_q       <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      data_q      <= data_d;
      wrap_q      <= wrap_d;
      burst_q     <= burst_d;
      gap_q       <= gap_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
    end
  end

  // Outputs are taken straight from registers, with no input-to-output paths.
  assign wr_data       = data_q;
  assign wr_data_valid = (state_q == S_RUN);
  assign busy          = (state_q == S_RUN) || (state_q == S_GAP);
  assign done          = done_q;
  assign wrap_count    = wrap_q;

endmodule

// File: tb/tb_ddr_fifo_pattern_gen.sv
// Self-checking bench for ddr_fifo_pattern_gen.
// u_dut: 8-bit counter with bursts, gaps and a wrap limit, checked against a
// cycle-level reference model plus a scoreboard of accepted words.
// u_cont: default 32-bit continuous stream, fed into a read-side style
// checker for 10k beats.
module tb_ddr_fifo_pattern_gen;

  localparam int          P_W     = 8;
  localparam logic [7:0]  P_START = 8'hFE;
  localparam int          P_BL    = 4;
  localparam int          P_GAP   = 3;
  localparam int          P_MW    = 2;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_GAP  = 2;
  localparam int M_DONE = 3;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic [P_W-1:0]   wr_data;
  logic             wr_data_valid;
  logic             wr_data_ready;
  logic [31:0]      wrap_count;
  logic             busy;
  logic             done;

  logic             c_rst_n;
  logic             c_start;
  logic             c_stop;
  logic [31:0]      c_data;
  logic             c_valid;
  logic             c_ready;
  logic [31:0]      c_wrap;
  logic             c_busy;
  logic             c_done;

  int vectors = 0;
  int errors  = 0;

  // Reference model state.
  int         m_mode;
  logic [7:0] m_word;
  logic [31:0] m_wraps;
  int         m_beats;
  int         m_gap_left;
  bit         m_stop_latched;
  bit         m_done;
  logic [7:0] exp_q[$];

  ddr_fifo_pattern_gen #(
    .DATA_W    (P_W),
    .START_VAL (P_START),
    .BURST_LEN (P_BL),
    .GAP_CYCLES(P_GAP),
    .MAX_WRAPS (P_MW)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .wr_data      (wr_data),
    .wr_data_valid(wr_data_valid),
    .wr_data_ready(wr_data_ready),
    .wrap_count   (wrap_count),
    .busy         (busy),
    .done         (done)
  );

  ddr_fifo_pattern_gen #(
    .DATA_W(32)
  ) u_cont (
    .clk          (clk),
    .rst_n        (c_rst_n),
    .start        (c_start),
    .stop         (c_stop),
    .wr_data      (c_data),
    .wr_data_valid(c_valid),
    .wr_data_ready(c_ready),
    .wrap_count   (c_wrap),
    .busy         (c_busy),
    .done         (c_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode         = M_IDLE;
    m_word         = P_START;
    m_wraps        = '0;
    m_beats        = 0;
    m_gap_left     = 0;
    m_stop_latched = 1'b0;
    m_done         = 1'b0;
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input bit s, input bit p, input bit r);
    bit was_ff;
    case (m_mode)
      M_IDLE, M_DONE: begin
        if (s && !p) begin
          m_mode         = M_RUN;
          m_word         = P_START;
          m_wraps        = '0;
          m_beats        = 0;
          m_done         = 1'b0;
          m_stop_latched = 1'b0;
        end
      end
      M_RUN: begin
        if (r) begin
          exp_q.push_back(m_word);
          was_ff = (m_word == 8'hFF);
          if (was_ff && m_wraps != 32'hFFFF_FFFF) m_wraps = m_wraps + 32'd1;
          m_word  = m_word + 8'd1;
          m_beats = m_beats + 1;
          if (P_MW != 0 && was_ff && m_wraps == 32'(P_MW)) begin
            m_mode = M_DONE;
            m_done = 1'b1;
          end else if (p || m_stop_latched) begin
            m_mode = M_IDLE;
          end else if (P_BL != 0 && m_beats == P_BL) begin
            m_beats = 0;
            if (P_GAP != 0) begin
              m_mode     = M_GAP;
              m_gap_left = P_GAP;
            end
          end
          m_stop_latched = 1'b0;
        end else if (p) begin
          m_stop_latched = 1'b1;
        end
      end
      M_GAP: begin
        if (p) begin
          m_mode = M_IDLE;
        end else begin
          m_gap_left = m_gap_left - 1;
          if (m_gap_left == 0) m_mode = M_RUN;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic check_outputs();
    check("valid", wr_data_valid, m_mode == M_RUN);
    check("busy", busy, (m_mode == M_RUN) || (m_mode == M_GAP));
    check("done", done, m_done);
    check("wrap_count", wrap_count, m_wraps);
    check("wr_data", wr_data, m_word);
  endtask

  task automatic drive_cycle(input bit s, input bit p, input bit r);
    @(negedge clk);
    check_outputs();
    start         = s;
    stop          = p;
    wr_data_ready = r;
    model_step(s, p, r);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    start         = 1'b0;
    stop          = 1'b0;
    wr_data_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", wr_data_valid, 1'b0);
    check("rst_data", wr_data, P_START);
    check("rst_wrap", wrap_count, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: every beat the DUT is about to hand over is compared
  // with the oldest word the model predicted.
  initial begin : monitor
    logic [7:0] exp_w;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && wr_data_valid && wr_data_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL beat_unexpected: got %0h expected no beat at %0t", wr_data, $time);
        end else begin
          exp_w = exp_q.pop_front();
          check("beat_data", wr_data, exp_w);
        end
      end
    end
  end

  initial begin : main
    start         = 1'b0;
    stop          = 1'b0;
    wr_data_ready = 1'b0;
    rst_n         = 1'b0;
    c_rst_n       = 1'b0;
    c_start       = 1'b0;
    c_stop        = 1'b0;
    c_ready       = 1'b0;
    model_reset();

    fork
      begin : main_thread
        bit s, p, r;
        repeat (2) @(negedge clk);
        check("init_valid", wr_data_valid, 1'b0);
        check("init_data", wr_data, P_START);
        check("init_wrap", wrap_count, 32'd0);
        check("init_busy", busy, 1'b0);
        check("init_done", done, 1'b0);
        rst_n = 1'b1;

        // Start, then ready 1,0,0,1: FE accepted, FF held over the stall.
        drive_cycle(1, 0, 0);
        drive_cycle(0, 0, 1);
        drive_cycle(0, 0, 0);
        drive_cycle(0, 0, 0);
        drive_cycle(0, 0, 1);
        // Stop while stalled: the pending word still goes out, then idle.
        drive_cycle(0, 1, 0);
        drive_cycle(0, 0, 0);
        drive_cycle(0, 0, 1);
        repeat (3) drive_cycle(0, 0, 1);

        // Full-throughput run up to the wrap limit (bursts of 4, gaps of 3).
        drive_cycle(1, 0, 1);
        repeat (600) drive_cycle(0, 0, 1);
        // start and stop together while done: stop wins.
        drive_cycle(1, 1, 1);
        repeat (2) drive_cycle(0, 0, 1);

        // Reset in the middle of a burst.
        drive_cycle(1, 0, 1);
        drive_cycle(0, 0, 1);
        drive_cycle(0, 0, 1);
        do_reset();
        repeat (2) drive_cycle(0, 0, 1);

        // Random start/stop/ready traffic, with one more reset halfway.
        for (int i = 0; i < 5000; i++) begin
          s = ($urandom_range(15) == 0);
          p = ($urandom_range(149) == 0);
          r = ($urandom_range(3) != 0);
          drive_cycle(s, p, r);
          if (i == 2500) do_reset();
        end
        drive_cycle(0, 0, 0);
        @(negedge clk);
        check_outputs();
        #2;
        check("scoreboard_drain", exp_q.size(), 0);
      end

      begin : cont_thread
        logic [31:0] exp_c;
        int beats;
        int cyc;
        repeat (3) @(negedge clk);
        check("cont_rst_valid", c_valid, 1'b0);
        check("cont_rst_data", c_data, 32'd0);
        c_rst_n = 1'b1;
        @(negedge clk);
        c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
        check("cont_valid_latency", c_valid, 1'b1);
        exp_c = 32'd0;
        beats = 0;
        cyc   = 0;
        while (beats < 10000 && cyc < 30000) begin
          c_ready = ($urandom_range(3) != 0);
          #1;
          check("cont_valid_held", c_valid, 1'b1);
          if (c_valid && c_ready) begin
            check("cont_data", c_data, exp_c);
            exp_c = exp_c + 32'd1;
            beats++;
          end
          cyc++;
          @(negedge clk);
        end
        check("cont_beat_budget", beats, 10000);
        check("cont_wrap", c_wrap, 32'd0);
        check("cont_done", c_done, 1'b0);
        check("cont_busy", c_busy, 1'b1);
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
